pipelined_register_file: RTL and testbench
==========================================

# pipelined_register_file

Parametrised successor to the core's 16x32 register bank. It provides two registered read ports, one write port with same-cycle write-to-read bypass, and a synchronous reset that clears the whole array. A per-register busy scoreboard tracks writes that have been issued but not yet written back. It sits between decode (read and reserve) and write-back (write); the hazard unit uses the busy flags to stall.

## Interface
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 4, register address width; depth = 2**ADDR_WIDTH.
- ZERO_REG, 0, if 1 then register 0 is hardwired to zero: writes and reserves to it are ignored, it always reads 0 and is never busy.

Ports:
- ClockInput  in  1  single clock; all state updates on posedge.
- ResetInput  in  1  synchronous, active-high reset.
- Rprimary  in  ADDR_WIDTH  read address, port A.
- Rsecondary  in  ADDR_WIDTH  read address, port B.
- Rwrite  in  ADDR_WIDTH  write-back address.
- WriteRegSignal  in  1  write-back enable; also clears the busy bit of Rwrite.
- WriteData  in  DATA_WIDTH  write-back data.
- ReserveSignal  in  1  marks Rreserve busy (write issued, result pending).
- Rreserve  in  ADDR_WIDTH  register being reserved.
- ReadPrimary  out  DATA_WIDTH  registered data, port A.
- ReadSecondary  out  DATA_WIDTH  registered data, port B.
- BusyPrimary  out  1  registered busy flag for the port-A register.
- BusySecondary  out  1  registered busy flag for the port-B register.
- BusyCount  out  ADDR_WIDTH+1  number of busy registers, registered.

## Operation
- State: the register array Reg[0..DEPTH-1], the busy vector busy[0..DEPTH-1], and the output registers.
- Reset (ResetInput=1 at a posedge):
  - all Reg, all busy bits, ReadPrimary, ReadSecondary, BusyPrimary, BusySecondary and BusyCount go to 0.
  - Reset overrides any write, reserve or read in the same cycle.
  - A reset mid-operation discards all pending reservations.
- Write: on a posedge with WriteRegSignal=1, Reg[Rwrite] <= WriteData. If ZERO_REG=1 and Rwrite=0, the write is dropped.
- Read data, computed combinationally in the cycle and registered at the posedge:
  - port A: if WriteRegSignal=1 and Rwrite==Rprimary (and the write is not dropped), ReadPrimary <= WriteData (bypass); otherwise ReadPrimary <= Reg[Rprimary].
  - port B: same rule with Rsecondary / ReadSecondary.
  - Both ports may address the same register; each then returns the same value.
- Busy bits:
  - busy_next[i] = (busy[i] AND NOT(WriteRegSignal AND Rwrite==i)) OR (ReserveSignal AND Rreserve==i).
  - If a write and a reserve hit the same register in the same cycle, the reserve wins and the bit stays 1 (a new owner).
  - Reserving an already-busy register keeps it at 1; there is no nesting count.
  - A write to a non-busy register is legal and leaves its bit at 0.
  - With ZERO_REG=1, busy[0] is constant 0.
- Busy outputs: BusyPrimary <= busy_next[Rprimary] and BusySecondary <= busy_next[Rsecondary]. The flags therefore reflect the same-cycle clear and reserve, consistent with the bypass.
- BusyCount <= popcount(busy_next). Its maximum is DEPTH, so the width is ADDR_WIDTH+1 with no wrap.

## Timing
- Read latency is 1 cycle: an address applied in cycle N is visible on ReadPrimary/ReadSecondary and the busy outputs after posedge N (cycle N+1).
- Write latency is 1 cycle. A read issued in the same cycle sees the new value through the bypass; a read in any later cycle sees it from the array.
- The outputs hold their values between posedges; there is no read enable.
- Reserve takes effect at the posedge: a read of Rreserve in the same cycle reports busy=1 in the next cycle.
- The cycle after reset deasserts, every read returns 0 and not busy.

## Test plan
- Reset then read: assert ResetInput for 2 cycles, then read Rprimary=5 and Rsecondary=15 -> ReadPrimary=0, ReadSecondary=0, BusyPrimary=0, BusySecondary=0, BusyCount=0 in the next cycle.
- Write then read back: write Rwrite=7 with WriteData=543 in cycle N, read Rprimary=7 in cycle N+1 -> ReadPrimary=543 in cycle N+2.
- Same-cycle bypass: in one cycle write Rwrite=9 with WriteData=890 and read Rprimary=9 and Rsecondary=9 -> ReadPrimary=ReadSecondary=890 in the next cycle (the old value is never shown).
- Scoreboard:
  - reserve register 2 -> the next read of 2 shows BusyPrimary=1, BusyCount=1;
  - then write register 2 with 100 -> busy clears, BusyCount=0;
  - then write 3 and reserve 3 in the same cycle -> busy[3]=1 and BusyCount=1.
- ZERO_REG=1 build: write 32'hFFFFFFFF to register 0 and reserve register 0 -> reads of 0 return 0 with BusyPrimary=0, BusyCount=0.
- Reset mid-operation: reserve registers 1, 4 and 10, write register 1 with 45, then assert reset in the same cycle as a write to register 4 -> after reset all data reads are 0 and BusyCount=0.

Source files
------------

// File: rtl/pipelined_register_file_if.sv
// Bus between decode/write-back and the pipelined register file.
// Grouped so both read ports, the write port and the reserve port travel together.
interface pipelined_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] Rprimary;
    logic [ADDR_WIDTH-1:0] Rsecondary;
    logic [ADDR_WIDTH-1:0] Rwrite;
    logic                  WriteRegSignal;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  ReserveSignal;
    logic [ADDR_WIDTH-1:0] Rreserve;
    logic [DATA_WIDTH-1:0] ReadPrimary;
    logic [DATA_WIDTH-1:0] ReadSecondary;
    logic                  BusyPrimary;
    logic                  BusySecondary;
    logic [ADDR_WIDTH:0]   BusyCount;

    modport master (
        output Rprimary, Rsecondary, Rwrite, WriteRegSignal, WriteData,
               ReserveSignal, Rreserve,
        input  ReadPrimary, ReadSecondary, BusyPrimary, BusySecondary, BusyCount
    );

    modport slave (
        input  Rprimary, Rsecondary, Rwrite, WriteRegSignal, WriteData,
               ReserveSignal, Rreserve,
        output ReadPrimary, ReadSecondary, BusyPrimary, BusySecondary, BusyCount
    );
endinterface

// File: rtl/pipelined_register_file.sv
// Register bank with two registered read ports, write-to-read bypass and a
// per-register busy scoreboard used by the hazard unit to stall.
module pipelined_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int ZERO_REG   = 0
) (
    input  logic ClockInput,
    input  logic ResetInput,
    pipelined_register_file_if.slave bus
);
    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] reg_q [DEPTH];
    logic [DATA_WIDTH-1:0] reg_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [DATA_WIDTH-1:0] read_primary_q;
    logic [DATA_WIDTH-1:0] read_primary_d;
    logic [DATA_WIDTH-1:0] read_secondary_q;
    logic [DATA_WIDTH-1:0] read_secondary_d;
    logic                  busy_primary_q;
    logic                  busy_primary_d;
    logic                  busy_secondary_q;
    logic                  busy_secondary_d;
    logic [ADDR_WIDTH:0]   busy_count_q;
    logic [ADDR_WIDTH:0]   busy_count_d;
    logic                  write_ok;

    always_comb begin
        write_ok = bus.WriteRegSignal && !(ZERO_EN && (bus.Rwrite == '0));

        reg_d = reg_q;
        if (write_ok) begin
            reg_d[bus.Rwrite] = bus.WriteData;
        end

        // A reserve landing on the register being written back wins: it is a new owner.
        busy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_d[i] = (busy_q[i] && !(bus.WriteRegSignal && (bus.Rwrite == ADDR_WIDTH'(i))))
                        || (bus.ReserveSignal && (bus.Rreserve == ADDR_WIDTH'(i)));
        end
        if (ZERO_EN) begin
            busy_d[0] = 1'b0;
        end

        if (write_ok && (bus.Rwrite == bus.Rprimary)) begin
            read_primary_d = bus.WriteData;
        end else begin
            read_primary_d = reg_q[bus.Rprimary];
        end

        if (write_ok && (bus.Rwrite == bus.Rsecondary)) begin
            read_secondary_d = bus.WriteData;
        end else begin
            read_secondary_d = reg_q[bus.Rsecondary];
        end

        busy_primary_d   = busy_d[bus.Rprimary];
        busy_secondary_d = busy_d[bus.Rsecondary];

        busy_count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_count_d = busy_count_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge ClockInput) begin
        if (ResetInput) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i] <= '0;
            end
            busy_q           <= '0;
            read_primary_q   <= '0;
            read_secondary_q <= '0;
            busy_primary_q   <= 1'b0;
            busy_secondary_q <= 1'b0;
            busy_count_q     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i] <= reg_d[i];
            end
            busy_q           <= busy_d;
            read_primary_q   <= read_primary_d;
            read_secondary_q <= read_secondary_d;
            busy_primary_q   <= busy_primary_d;
            busy_secondary_q <= busy_secondary_d;
            busy_count_q     <= busy_count_d;
        end
    end

    assign bus.ReadPrimary   = read_primary_q;
    assign bus.ReadSecondary = read_secondary_q;
    assign bus.BusyPrimary   = busy_primary_q;
    assign bus.BusySecondary = busy_secondary_q;
    assign bus.BusyCount     = busy_count_q;
endmodule

// File: tb/tb_pipelined_register_file.sv
// Scoreboard bench driving a ZERO_REG=0 and a ZERO_REG=1 instance with identical stimulus.
module tb_pipelined_register_file;
    logic clock;
    logic reset;

    pipelined_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus_n ();
    pipelined_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus_z ();

    pipelined_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(0)) dut (
        .ClockInput (clock),
        .ResetInput (reset),
        .bus        (bus_n)
    );

    pipelined_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(1)) dut_z (
        .ClockInput (clock),
        .ResetInput (reset),
        .bus        (bus_z)
    );

    typedef struct {
        int          variant;
        string       tag;
        logic [31:0] rp;
        logic [31:0] rs;
        logic        bp;
        logic        bs;
        logic [4:0]  cnt;
    } expect_t;

    expect_t     exp_q[$];
    logic [31:0] m_reg [2][16];
    logic [15:0] m_busy [2];
    int          compared;
    int          mismatched;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of stimulus on both instances and queues what each must show after the edge.
    task automatic applyStimulus(input string tag, input logic rst,
                                 input logic [3:0] ra, input logic [3:0] rb,
                                 input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                 input logic rs, input logic [3:0] rsa);
        @(negedge clock);
        reset = rst;
        bus_n.Rprimary = ra;  bus_z.Rprimary = ra;
        bus_n.Rsecondary = rb; bus_z.Rsecondary = rb;
        bus_n.WriteRegSignal = we; bus_z.WriteRegSignal = we;
        bus_n.Rwrite = wa; bus_z.Rwrite = wa;
        bus_n.WriteData = wd; bus_z.WriteData = wd;
        bus_n.ReserveSignal = rs; bus_z.ReserveSignal = rs;
        bus_n.Rreserve = rsa; bus_z.Rreserve = rsa;
        for (int v = 0; v < 2; v++) begin
            expect_t     e;
            logic        zr;
            logic        wr_ok;
            logic [15:0] nb;
            zr = (v == 1);
            e.variant = v;
            e.tag = tag;
            if (rst) begin
                e.rp = '0; e.rs = '0; e.bp = 1'b0; e.bs = 1'b0; e.cnt = '0;
                for (int i = 0; i < 16; i++) m_reg[v][i] = '0;
                m_busy[v] = '0;
            end else begin
                wr_ok = we && !(zr && wa == 4'd0);
                for (int i = 0; i < 16; i++) begin
                    nb[i] = (m_busy[v][i] && !(we && wa == 4'(i))) || (rs && rsa == 4'(i));
                end
                if (zr) nb[0] = 1'b0;
                e.rp  = (wr_ok && wa == ra) ? wd : m_reg[v][ra];
                e.rs  = (wr_ok && wa == rb) ? wd : m_reg[v][rb];
                e.bp  = nb[ra];
                e.bs  = nb[rb];
                e.cnt = 5'($countones(nb));
                if (wr_ok) m_reg[v][wa] = wd;
                m_busy[v] = nb;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic readRegs(input string tag, input logic [3:0] ra, input logic [3:0] rb);
        applyStimulus(tag, 1'b0, ra, rb, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            while (exp_q.size() > 0) begin
                expect_t e;
                e = exp_q.pop_front();
                if (e.variant == 0) begin
                    checkOutput({e.tag, "/z0 ReadPrimary"}, bus_n.ReadPrimary, e.rp);
                    checkOutput({e.tag, "/z0 ReadSecondary"}, bus_n.ReadSecondary, e.rs);
                    checkOutput({e.tag, "/z0 BusyPrimary"}, {31'd0, bus_n.BusyPrimary}, {31'd0, e.bp});
                    checkOutput({e.tag, "/z0 BusySecondary"}, {31'd0, bus_n.BusySecondary}, {31'd0, e.bs});
                    checkOutput({e.tag, "/z0 BusyCount"}, {27'd0, bus_n.BusyCount}, {27'd0, e.cnt});
                end else begin
                    checkOutput({e.tag, "/z1 ReadPrimary"}, bus_z.ReadPrimary, e.rp);
                    checkOutput({e.tag, "/z1 ReadSecondary"}, bus_z.ReadSecondary, e.rs);
                    checkOutput({e.tag, "/z1 BusyPrimary"}, {31'd0, bus_z.BusyPrimary}, {31'd0, e.bp});
                    checkOutput({e.tag, "/z1 BusySecondary"}, {31'd0, bus_z.BusySecondary}, {31'd0, e.bs});
                    checkOutput({e.tag, "/z1 BusyCount"}, {27'd0, bus_z.BusyCount}, {27'd0, e.cnt});
                end
            end
        end
    end

    initial begin
        compared = 0;
        mismatched = 0;
        reset = 1'b1;
        bus_n.Rprimary = '0; bus_n.Rsecondary = '0; bus_n.Rwrite = '0; bus_n.WriteRegSignal = 1'b0;
        bus_n.WriteData = '0; bus_n.ReserveSignal = 1'b0; bus_n.Rreserve = '0;
        bus_z.Rprimary = '0; bus_z.Rsecondary = '0; bus_z.Rwrite = '0; bus_z.WriteRegSignal = 1'b0;
        bus_z.WriteData = '0; bus_z.ReserveSignal = 1'b0; bus_z.Rreserve = '0;
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < 16; i++) m_reg[v][i] = '0;
            m_busy[v] = '0;
        end

        applyStimulus("reset0", 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        applyStimulus("reset1", 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        readRegs("after_reset", 4'd5, 4'd15);

        applyStimulus("write7", 1'b0, 4'd0, 4'd0, 1'b1, 4'd7, 32'd543, 1'b0, 4'd0);
        readRegs("readback7", 4'd7, 4'd6);

        applyStimulus("bypass9", 1'b0, 4'd9, 4'd9, 1'b1, 4'd9, 32'd890, 1'b0, 4'd0);
        readRegs("read9", 4'd9, 4'd7);

        applyStimulus("reserve2", 1'b0, 4'd1, 4'd3, 1'b0, 4'd0, 32'd0, 1'b1, 4'd2);
        readRegs("busy2", 4'd2, 4'd3);
        applyStimulus("write2", 1'b0, 4'd2, 4'd2, 1'b1, 4'd2, 32'd100, 1'b0, 4'd0);
        applyStimulus("wr_res3", 1'b0, 4'd3, 4'd2, 1'b1, 4'd3, 32'd77, 1'b1, 4'd3);
        readRegs("busy3", 4'd3, 4'd2);
        applyStimulus("reserve_busy3", 1'b0, 4'd3, 4'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd3);

        applyStimulus("zero_wr_res", 1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b1, 4'd0);
        readRegs("zero_read", 4'd0, 4'd15);

        applyStimulus("res1", 1'b0, 4'd1, 4'd4, 1'b0, 4'd0, 32'd0, 1'b1, 4'd1);
        applyStimulus("res4", 1'b0, 4'd1, 4'd4, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4);
        applyStimulus("res10", 1'b0, 4'd10, 4'd4, 1'b0, 4'd0, 32'd0, 1'b1, 4'd10);
        applyStimulus("wr1", 1'b0, 4'd1, 4'd10, 1'b1, 4'd1, 32'd45, 1'b0, 4'd0);
        applyStimulus("mid_reset", 1'b1, 4'd4, 4'd1, 1'b1, 4'd4, 32'd123, 1'b1, 4'd6);
        readRegs("post_reset_a", 4'd1, 4'd4);
        readRegs("post_reset_b", 4'd7, 4'd10);

        for (int n = 0; n < 300; n++) begin
            applyStimulus("random", ($urandom_range(0, 39) == 0),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        readRegs("final", 4'd15, 4'd0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
        #3;
        checkOutput("drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
